// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clkdiv_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  // Unsigned |a - b|; operands are zero-extended counter values well below 2**31,
  // so the 32-bit difference never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus one delay flop; yields the synchronized level
// and single-cycle rise/fall strobes. Reusable for any asynchronous input.
module sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // sh_q[0] = s1, sh_q[1] = s2, sh_q[2] = s3
  logic [2:0] sh_d;
  logic [2:0] sh_q;

  // Next value of the shift chain
  always_comb begin
    sh_d = {sh_q[1:0], async_in};
  end

  // Synchronizer and delay registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures period and high time of a divided clock in clk cycles, compares
// the period against an expected value and reports ok / out-of-range / stuck.
module clkdiv_monitor
  import clkdiv_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = 8,
  parameter int unsigned TOL        = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             div_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             ok,
  output logic             err_period,
  output logic             err_stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic div_level_unused;
  logic div_rise;
  logic div_fall;

  sync_edge u_sync (
    .clk      (clk),
    .clr      (clr),
    .async_in (div_in),
    .level    (div_level_unused),
    .rise     (div_rise),
    .fall     (div_fall)
  );

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_d, high_q;
  logic             valid_d, valid_q;
  logic             ok_d, ok_q;
  logic             errp_d, errp_q;
  logic             errs_d, errs_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             in_tol;

  // Saturating increment, timeout detect and tolerance compare on the live count
  always_comb begin
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    timeout_hit = (cnt_q == TIMEOUT_C);
    in_tol      = (abs_diff(32'(cnt_q), EXP_PERIOD) <= TOL);
  end

  // FSM next-state, counter and result update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ok_d     = ok_q;
    errp_d   = errp_q;
    errs_d   = errs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          cnt_d   = '0;
          ok_d    = 1'b0;
          errp_d  = 1'b0;
          errs_d  = 1'b0;
        end
      end
      ARM: begin
        // An edge arriving together with the timeout still starts a measurement
        if (div_rise) begin
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end else if (timeout_hit) begin
          errs_d  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        // Timeout takes priority here: past TIMEOUT the count could never
        // match it again and LOW would only end on a rise
        if (timeout_hit) begin
          errs_d  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (div_fall) begin
            high_d  = cnt_q;
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (div_rise) begin
          period_d = cnt_q;
          ok_d     = in_tol;
          errp_d   = ~in_tol;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          errs_d  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ok_q     <= 1'b0;
      errp_q   <= 1'b0;
      errs_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      errp_q   <= errp_d;
      errs_q   <= errs_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign valid      = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign ok         = ok_q;
  assign err_period = errp_q;
  assign err_stuck  = errs_q;

endmodule
